// File: rtl/scan_sequencer.sv
// Scans a 3-to-8 decoder (C/B/A select, G/G2A/G2B enables) across the positions enabled in mask,
// blanking the decoder for BLANK cycles at the start of each DWELL-cycle position; all outputs registered.
module scan_sequencer #(
  parameter int DWELL = 1000,
  parameter int BLANK = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       step_mode,
  input  logic       step,
  input  logic [7:0] mask,
  output logic       C,
  output logic       B,
  output logic       A,
  output logic       G,
  output logic       G2A,
  output logic       G2B,
  output logic [2:0] sel,
  output logic       frame_done,
  output logic       active
);

  typedef enum logic [1:0] {ST_IDLE, ST_BLANK, ST_ON} state_t;

  localparam logic [15:0] BLANK_LAST = 16'(BLANK - 1);
  localparam logic [15:0] ON_LAST    = 16'(DWELL - BLANK - 1);

  state_t      state_q, state_d;
  logic [2:0]  sel_q, sel_d;
  logic [15:0] cnt_q, cnt_d;
  logic        fd_q, fd_d;
  logic        dec_en_q, dec_en_d;
  logic        active_q, active_d;
  logic        adv;
  logic [2:0]  first_idx;
  logic [2:0]  next_idx;

  function automatic logic [2:0] lowest_set(input logic [7:0] m);
    logic [2:0] r;
    r = '0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) r = 3'(i);
    end
    return r;
  endfunction

  // Search upward from cur+1; distance 8 wraps back onto cur itself.
  function automatic logic [2:0] next_set(input logic [7:0] m, input logic [2:0] cur);
    logic [2:0] r;
    logic [2:0] idx;
    r = cur;
    for (int i = 8; i >= 1; i--) begin
      idx = cur + 3'(i);
      if (m[idx]) r = idx;
    end
    return r;
  endfunction

  assign first_idx = lowest_set(mask);
  assign next_idx  = next_set(mask, sel_q);

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    fd_d    = 1'b0;
    adv     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (mask != 8'd0) begin
          state_d = ST_BLANK;
          sel_d   = first_idx;
          cnt_d   = '0;
        end
      end
      ST_BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          state_d = ST_ON;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_ON: begin
        // Count saturates so a long manual hold still advances when free-running resumes.
        if (step_mode ? step : (cnt_q >= ON_LAST)) adv = 1'b1;
        else if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
      end
      default: state_d = ST_IDLE;
    endcase

    if (adv) begin
      cnt_d = '0;
      if (mask == 8'd0) begin
        state_d = ST_IDLE;
        sel_d   = '0;
      end else begin
        state_d = ST_BLANK;
        sel_d   = next_idx;
        fd_d    = (next_idx <= sel_q);
      end
    end

    if (!en) begin
      state_d = ST_IDLE;
      sel_d   = '0;
      cnt_d   = '0;
      fd_d    = 1'b0;
    end

    dec_en_d = (state_d == ST_ON);
    active_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      sel_q    <= '0;
      cnt_q    <= '0;
      fd_q     <= 1'b0;
      dec_en_q <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      cnt_q    <= cnt_d;
      fd_q     <= fd_d;
      dec_en_q <= dec_en_d;
      active_q <= active_d;
    end
  end

  assign {C, B, A}  = sel_q;
  assign sel        = sel_q;
  assign G          = dec_en_q;
  assign G2A        = ~dec_en_q;
  assign G2B        = ~dec_en_q;
  assign frame_done = fd_q;
  assign active     = active_q;

endmodule

// File: tb/tb_scan_sequencer.sv
// Randomised and directed bench for scan_sequencer (DWELL=8, BLANK=2) against a position/time model.
module tb_scan_sequencer;

  localparam int TD = 8;
  localparam int TB = 2;

  logic       clk = 1'b0;
  logic       rst, en, step_mode, step;
  logic [7:0] mask;
  logic       C, B, A, G, G2A, G2B, frame_done, active;
  logic [2:0] sel;
  logic [10:0] obs;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Model: is a position selected, which index, cycles elapsed within it, wrap pulse.
  bit m_active;
  int m_sel;
  int m_t;
  bit m_fd;

  scan_sequencer #(.DWELL(TD), .BLANK(TB)) dut (
    .clk(clk), .rst(rst), .en(en), .step_mode(step_mode), .step(step), .mask(mask),
    .C(C), .B(B), .A(A), .G(G), .G2A(G2A), .G2B(G2B),
    .sel(sel), .frame_done(frame_done), .active(active)
  );

  always #5 clk = ~clk;

  assign obs = {active, frame_done, G, G2A, G2B, sel, C, B, A};

  function automatic logic [10:0] exp_vec();
    logic g;
    logic [2:0] s;
    g = m_active && (m_t >= TB);
    s = 3'(m_sel);
    return {m_active, m_fd, g, ~g, ~g, s, s};
  endfunction

  function automatic int m_lowest(input logic [7:0] m);
    for (int i = 0; i < 8; i++) if (m[i]) return i;
    return 0;
  endfunction

  function automatic int m_next(input logic [7:0] m, input int cur);
    for (int d = 1; d <= 8; d++) if (m[(cur + d) % 8]) return (cur + d) % 8;
    return 0;
  endfunction

  task automatic model_edge();
    int nxt;
    bit done;
    m_fd = 0;
    if (rst || !en) begin
      m_active = 0; m_sel = 0; m_t = 0;
    end else if (!m_active) begin
      if (mask != 0) begin
        m_active = 1; m_sel = m_lowest(mask); m_t = 0;
      end
    end else begin
      done = (m_t >= TB) && (step_mode ? step : (m_t + 1 >= TD));
      if (done) begin
        m_t = 0;
        if (mask == 0) begin
          m_active = 0; m_sel = 0;
        end else begin
          nxt = m_next(mask, m_sel);
          m_fd = (nxt <= m_sel);
          m_sel = nxt;
        end
      end else if (m_t < 1000000) begin
        m_t++;
      end
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    rst = 1; en = 1; step_mode = 0; step = 0; mask = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++;
      if (obs !== exp_vec()) begin
        fails++;
        $display("FAIL reset cyc %0d got %b want %b", cyc, obs, exp_vec());
      end
      tests++;
      if ({G, G2A, G2B, sel, active, frame_done} !== 8'b0_11_000_0_0) begin
        fails++;
        $display("FAIL reset_const cyc %0d got %b want 01100000", cyc, {G, G2A, G2B, sel, active, frame_done});
      end
    end
    rst = 0;
  endtask

  task automatic test_free_run();
    int pulses = 0;
    mask = 8'hFF; en = 1; step_mode = 0;
    for (int i = 0; i < TD * 9 + 4; i++) begin
      tick();
      if (frame_done === 1'b1) pulses++;
      tests++;
      if (obs !== exp_vec()) begin
        fails++;
        $display("FAIL free_run cyc %0d got %b want %b", cyc, obs, exp_vec());
      end
    end
    tests++;
    if (pulses !== 1) begin
      fails++;
      $display("FAIL free_run_pulses got %0d want 1", pulses);
    end
  endtask

  task automatic test_sparse_mask();
    bit found = 0;
    en = 0; tick(); en = 1;
    mask = 8'b1010_0100;
    for (int i = 0; i < 40; i++) begin
      tick();
      tests++;
      if (obs !== exp_vec()) begin
        fails++;
        $display("FAIL sparse cyc %0d got %b want %b", cyc, obs, exp_vec());
      end
    end
    for (int i = 0; i < 100 && !found; i++) begin
      if (m_active && m_sel == 5 && m_t == 4) found = 1;
      else tick();
    end
    tests++;
    if (!found) begin
      fails++;
      $display("FAIL sparse_wait got timeout want sel 5 mid-ON");
    end
    mask = 8'h01;
    for (int i = 0; i < 30; i++) begin
      tick();
      tests++;
      if (obs !== exp_vec()) begin
        fails++;
        $display("FAIL sparse_remask cyc %0d got %b want %b", cyc, obs, exp_vec());
      end
    end
  endtask

  task automatic test_single_bit();
    en = 0; tick(); en = 1;
    mask = 8'h10;
    for (int i = 0; i < 40; i++) begin
      tick();
      tests++;
      if (obs !== exp_vec()) begin
        fails++;
        $display("FAIL single_bit cyc %0d got %b want %b", cyc, obs, exp_vec());
      end
    end
  endtask

  task automatic test_step_mode();
    // Phases: enter, step-in-BLANK, long hold, step, hold, resume free-running.
    rst = 1; tick(); rst = 0;
    step_mode = 1; mask = 8'hFF; en = 1; step = 0;
    for (int i = 0; i < 124; i++) begin
      step = (i == 1 || i == 110);
      if (i == 120) step_mode = 0;
      tick();
      tests++;
      if (obs !== exp_vec()) begin
        fails++;
        $display("FAIL step_mode cyc %0d got %b want %b", cyc, obs, exp_vec());
      end
    end
    step = 0;
  endtask

  task automatic test_abort();
    bit found;
    step_mode = 0; mask = 8'hFF;
    for (int k = 0; k < 3; k++) begin
      en = 0; tick(); en = 1;
      found = 0;
      for (int i = 0; i < 100 && !found; i++) begin
        if (m_active && m_sel == 3 && m_t >= TB + 2) found = 1;
        else tick();
      end
      tests++;
      if (!found) begin
        fails++;
        $display("FAIL abort_wait k=%0d got timeout want sel 3 ON", k);
      end
      if (k == 0) en = 0;
      else if (k == 1) rst = 1;
      else mask = 8'h00;
      for (int i = 0; i < TD + 2; i++) begin
        tick();
        rst = 0;
        tests++;
        if (obs !== exp_vec()) begin
          fails++;
          $display("FAIL abort k=%0d cyc %0d got %b want %b", k, cyc, obs, exp_vec());
        end
      end
      mask = 8'hFF;
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      rst  = ($urandom_range(0, 199) == 0);
      en   = ($urandom_range(0, 49) != 0);
      step = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 39) == 0) step_mode = ~step_mode;
      if ($urandom_range(0, 29) == 0)
        mask = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      tick();
      tests++;
      if (obs !== exp_vec()) begin
        fails++;
        $display("FAIL random cyc %0d got %b want %b", cyc, obs, exp_vec());
      end
    end
  endtask

  initial begin
    rst = 1; en = 0; step_mode = 0; step = 0; mask = 8'h00;
    m_active = 0; m_sel = 0; m_t = 0; m_fd = 0;
    test_reset();
    test_free_run();
    test_sparse_mask();
    test_single_bit();
    test_step_mode();
    test_abort();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/scan_sequencer.md
SCAN_SEQUENCER -- requirements
Module: scan_sequencer

Interface
REQ-001 SHALL have parameter DWELL, default 1000, meaning clock cycles per scan position including blanking; legal range 2..65535.
REQ-002 SHALL have parameter BLANK, default 4, meaning clock cycles per position during which the decoder is disabled; legal range 1..DWELL-1.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit; reset is synchronous and active-high.
REQ-005 SHALL have port en, input, 1 bit, run enable; low forces idle.
REQ-006 SHALL have port step_mode, input, 1 bit; 1 = manual advance, 0 = free-running.
REQ-007 SHALL have port step, input, 1 bit, single-cycle advance request, honoured only in step mode.
REQ-008 SHALL have port mask, input, 8 bits; bit i = 1 enables scan position i.
REQ-009 SHALL have ports C, B, A, outputs, 1 bit each, decoder select ({C,B,A} = position).
REQ-010 SHALL have ports G, G2A, G2B, outputs, 1 bit each, decoder enables (enabled only when G=1, G2A=0, G2B=0).
REQ-011 SHALL have port sel, output, 3 bits, equal to {C,B,A} at all times.
REQ-012 SHALL have port frame_done, output, 1 bit, one-cycle pulse on wrap-around.
REQ-013 SHALL have port active, output, 1 bit, high whenever state is not IDLE.

Function
REQ-014 SHALL implement states IDLE, BLANK, ON; all outputs registered, no combinational input-to-output path.
REQ-015 In IDLE and BLANK: G=0, G2A=1, G2B=1 (all decoder outputs inactive, Y=8'hFF).
REQ-016 In ON: G=1, G2A=0, G2B=0, so decoder output Y[sel] is low and all others high.
REQ-017 IDLE -> BLANK at the edge where en=1 and mask!=0; sel loads the lowest set bit index of mask at that same edge.
REQ-018 BLANK lasts exactly BLANK cycles, then -> ON; sel does not change in BLANK.
REQ-019 Free-running: ON lasts exactly DWELL-BLANK cycles, then advance; total period per position = DWELL cycles.
REQ-020 Step mode: ON persists indefinitely; advance on the edge where step=1; step in IDLE or BLANK ignored, not queued.
REQ-021 step_mode change takes effect on the next edge; switching to free-running while ON with dwell count >= DWELL-BLANK advances on the next edge.
REQ-022 Advance: sel <= next set mask bit strictly above current index, wrapping modulo 8; state -> BLANK; dwell counter cleared.
REQ-023 frame_done SHALL be 1 for exactly the cycle following an advance whose new index <= old index (wrap); otherwise 0.
REQ-024 Single set mask bit: advance reselects the same index, includes the BLANK interval, and pulses frame_done every advance.
REQ-025 mask sampled only at IDLE exit and at advance; mid-dwell mask changes do not cut the current position short.
REQ-026 mask==0 at an advance -> IDLE, sel=0, no frame_done.
REQ-027 en=0 sampled in any state -> IDLE on that edge; sel=0, counters cleared, no frame_done.
REQ-028 Dwell and blank counters SHALL be wide enough for DWELL without overflow (16 bits).

Reset
REQ-029 rst=1 at an edge SHALL force IDLE, sel={C,B,A}=0, G=0, G2A=1, G2B=1, frame_done=0, active=0, counters 0, overriding en and step.
REQ-030 rst asserted mid-BLANK or mid-ON SHALL produce the REQ-029 values after that edge; after rst release the sequence restarts from the lowest set mask bit per REQ-017.

Verification (DWELL=8, BLANK=2)
REQ-031 rst=1 for 3 cycles, en=1 -> G=0, G2A=1, G2B=1, sel=0, active=0, frame_done=0 throughout.
REQ-032 mask=8'hFF, en=1, step_mode=0 -> sel 0,1,...,7,0 each 8 cycles; enables active 6 of 8 cycles; frame_done one pulse on 7->0.
REQ-033 mask=8'b1010_0100 -> sel 2,5,7,2,...; frame_done only on 7->2; mask changed to 8'h01 mid-position 5 -> position 5 completes, then sel=0.
REQ-034 mask=8'h10 -> sel constant 4; decoder disabled 2 of every 8 cycles; frame_done every 8 cycles.
REQ-035 step_mode=1, mask=8'hFF -> ON held 100 cycles at sel=0; step during BLANK ignored; step in ON -> BLANK 2 cycles at sel=1, then ON.
REQ-036 en or rst asserted mid-ON at sel=3 -> next cycle G=0, G2A=1, G2B=1, sel=0, active=0, no frame_done.
